// File: rtl/uart_pkg.sv
// Shared constants, state encoding and divider helper for the 9-bit UART link.
package uart_pkg;

    localparam int unsigned DATA_BITS_DEF = 9;
    localparam int unsigned STOP_BITS     = 1;

    // Receiver states kept as plain constants so legacy RTL can compare them directly.
    typedef logic [1:0] rx_state_t;
    localparam rx_state_t IDLE  = 2'd0;
    localparam rx_state_t START = 2'd1;
    localparam rx_state_t DATA  = 2'd2;
    localparam rx_state_t STOP  = 2'd3;

    function automatic int unsigned calc_div(
        input int unsigned clk_hz,
        input int unsigned baud_rate,
        input int unsigned sample_rate
    );
        return clk_hz / (baud_rate * sample_rate);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEF
) ();

    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ack;
    logic                 framing_error;
    logic                 overrun;
    logic                 overrun_clear;
    logic                 busy;

    modport master (
        output data,
        output data_valid,
        output framing_error,
        output overrun,
        output busy,
        input  data_ack,
        input  overrun_clear
    );

    modport slave (
        input  data,
        input  data_valid,
        input  framing_error,
        input  overrun,
        input  busy,
        output data_ack,
        output overrun_clear
    );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick divider: one-cycle tick every DIV clocks, realignable with restart.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 162
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 9-bit LSB-first UART receiver: 2-flop synchroniser, mid-bit sampling FSM,
// valid/ack word handshake with framing-error pulse and sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned SAMPLE_RATE = 16,
    parameter int unsigned DATA_BITS   = DATA_BITS_DEF
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD_RATE, SAMPLE_RATE);
    localparam int unsigned TW  = $clog2(SAMPLE_RATE);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] HALF_LAST = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_s_q;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 brk_q, brk_d;
    logic                 restart;
    logic                 tick;
    logic                 stop_good;
    logic                 ovr_set;

    uart_rx_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        brk_d      = brk_q;
        restart    = 1'b0;
        fe_d       = 1'b0;
        stop_good  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // After a low stop bit, wait for the line to return high first.
                if (brk_q) begin
                    if (rx_s_q) begin
                        brk_d = 1'b0;
                    end
                end else if (!rx_s_q) begin
                    restart    = 1'b1;
                    tick_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        if (!rx_s_q) begin
                            tick_cnt_d = '0;
                            bit_idx_d  = '0;
                            state_d    = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_idx_d  = bit_idx_q + 1'b1;
                        if (bit_idx_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        if (rx_s_q) begin
                            stop_good = 1'b1;
                        end else begin
                            fe_d  = 1'b1;
                            brk_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A word load beats a same-cycle ack; an ack arriving with the load also suppresses overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_set = 1'b0;
        if (stop_good) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_set = valid_q && !bus.data_ack;
        end else if (bus.data_ack) begin
            valid_d = 1'b0;
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (bus.overrun_clear) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            ovr_q      <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fe_q       <= fe_d;
            ovr_q      <= ovr_d;
            brk_q      <= brk_d;
        end
    end

    assign bus.data          = data_q;
    assign bus.data_valid    = valid_q;
    assign bus.framing_error = fe_q;
    assign bus.overrun       = ovr_q;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames queue their expected words, a monitor checks them.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ   = 614_400;
    localparam int unsigned BAUD     = 9600;
    localparam int unsigned SR       = 16;
    localparam int unsigned DB       = 9;
    localparam int unsigned DIV      = CLK_HZ / (BAUD * SR);
    localparam int unsigned BITP     = DIV * SR;
    // Clocks from driving the stop bit to the edge that loads the word.
    localparam int unsigned LOAD_OFS = (SR / 2) * DIV + 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(
        .CLK_HZ      (CLK_HZ),
        .BAUD_RATE   (BAUD),
        .SAMPLE_RATE (SR),
        .DATA_BITS   (DB)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          fe;
        logic [DB-1:0] word;
        logic          ovr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Caller must be positioned just after a negedge; returns just after a negedge.
    task automatic send_frame(input logic [DB-1:0] w, input logic stop_val, input logic ack_at_load);
        rx = 1'b0;
        repeat (BITP) @(negedge clock);
        for (int i = 0; i < DB; i++) begin
            rx = w[i];
            repeat (BITP) @(negedge clock);
        end
        rx = stop_val;
        if (ack_at_load) begin
            repeat (LOAD_OFS) @(negedge clock);
            bus.data_ack = 1'b1;
            @(negedge clock);
            bus.data_ack = 1'b0;
            repeat (BITP - LOAD_OFS - 1) @(negedge clock);
        end else begin
            repeat (BITP) @(negedge clock);
        end
        rx = 1'b1;
    endtask

    task automatic ack_word();
        bus.data_ack = 1'b1;
        @(negedge clock);
        bus.data_ack = 1'b0;
        @(negedge clock);
        check("ack_clears_valid", bus.data_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, bus.data, 0);
        check({tag, "_valid"}, bus.data_valid, 0);
        check({tag, "_fe"}, bus.framing_error, 0);
        check({tag, "_ovr"}, bus.overrun, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    // Monitor: a new word or a framing pulse pops one expectation.
    initial begin
        logic          pv;
        logic [DB-1:0] pd;
        logic          nw;
        exp_t          e;
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge clock);
            nw = bus.data_valid && (!pv || bus.data != pd);
            if (!reset && (bus.framing_error || nw)) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got data=%0h fe=%0b required nothing",
                             bus.data, bus.framing_error);
                end else begin
                    e = exp_q.pop_front();
                    check("fe_flag", bus.framing_error, e.fe);
                    if (!e.fe) begin
                        check("word", bus.data, e.word);
                        check("word_overrun", bus.overrun, e.ovr);
                    end
                end
            end
            pv = bus.data_valid;
            pd = bus.data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DB-1:0] w;
        bus.data_ack      = 1'b0;
        bus.overrun_clear = 1'b0;

        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Plain word.
        exp_q.push_back('{1'b0, 9'h1A5, 1'b0});
        send_frame(9'h1A5, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        ack_word();

        // Short low glitch: rejected at mid start bit.
        rx = 1'b0;
        repeat (20) @(negedge clock);
        check("glitch_busy_high", bus.busy, 1);
        rx = 1'b1;
        repeat (40) @(negedge clock);
        check("glitch_busy_low", bus.busy, 0);
        check("glitch_valid", bus.data_valid, 0);

        // Framing error, then recovery.
        exp_q.push_back('{1'b1, 9'h000, 1'b0});
        send_frame(9'h0FF, 1'b0, 1'b0);
        check("fe_data_kept", bus.data, 9'h1A5);
        check("fe_valid_kept", bus.data_valid, 0);
        repeat (10) @(negedge clock);
        exp_q.push_back('{1'b0, 9'h003, 1'b0});
        send_frame(9'h003, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        ack_word();

        // Back-to-back without ack: overrun.
        exp_q.push_back('{1'b0, 9'h001, 1'b0});
        exp_q.push_back('{1'b0, 9'h100, 1'b1});
        send_frame(9'h001, 1'b1, 1'b0);
        send_frame(9'h100, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        check("ovr_set", bus.overrun, 1);
        check("ovr_data", bus.data, 9'h100);
        check("ovr_valid", bus.data_valid, 1);
        bus.overrun_clear = 1'b1;
        @(negedge clock);
        bus.overrun_clear = 1'b0;
        @(negedge clock);
        check("ovr_cleared", bus.overrun, 0);
        ack_word();

        // Ack in the same cycle as the second load.
        exp_q.push_back('{1'b0, 9'h0AA, 1'b0});
        exp_q.push_back('{1'b0, 9'h133, 1'b0});
        send_frame(9'h0AA, 1'b1, 1'b0);
        send_frame(9'h133, 1'b1, 1'b1);
        repeat (5) @(negedge clock);
        check("ack_load_valid", bus.data_valid, 1);
        check("ack_load_ovr", bus.overrun, 0);

        // Reset during data bit 4.
        w  = 9'h0F0;
        rx = 1'b0;
        repeat (BITP) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            rx = w[i];
            repeat (BITP) @(negedge clock);
        end
        rx = w[4];
        repeat (BITP / 2) @(negedge clock);
        check("midframe_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midreset");
        reset = 1'b0;
        rx    = 1'b1;
        repeat (2 * BITP) @(negedge clock);
        exp_q.push_back('{1'b0, 9'h155, 1'b0});
        send_frame(9'h155, 1'b1, 1'b0);
        repeat (5) @(negedge clock);
        ack_word();

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
